// File: rtl/sc_run_pkg.sv
// Shared encodings for the single-cycle computer run controller.
package sc_run_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_HALT    = 3'd2,
    OP_STEP    = 3'd3,
    OP_SET_BP  = 3'd4,
    OP_CLR_BP  = 3'd5,
    OP_CPU_RST = 3'd6,
    OP_CLR_CNT = 3'd7
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_CRST = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } run_state_t;

  localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/sc_run_ctrl.sv
// Run controller: sequences the CPU with a per-cycle enable and reset,
// supporting halt, run, single-step, one PC breakpoint and a retire counter.
module sc_run_ctrl
  import sc_run_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RST_CYC = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             halted,
  output logic             bp_hit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);

  run_state_t    state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          bp_valid_q, bp_valid_d;
  logic [31:0]   bp_addr_q, bp_addr_d;
  logic          bp_hit_q, bp_hit_d;
  logic          skip_q, skip_d;
  logic          accept;
  logic          bp_match;
  logic          enter_crst;
  logic          clr_cnt;
  cmd_op_t       op;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign bp_match  = bp_valid_q && (pc == bp_addr_q) && !skip_q;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    bp_hit_d   = bp_hit_q;
    skip_d     = skip_q;
    cpu_en     = 1'b0;
    enter_crst = 1'b0;
    clr_cnt    = 1'b0;

    case (state_q)
      ST_CRST: begin
        if (rst_cnt_q == '0) state_d = ST_HALT;
        else                 rst_cnt_d = rst_cnt_q - RW'(1);
      end
      ST_HALT: begin
        if (accept) begin
          case (op)
            OP_RUN: begin
              state_d  = ST_RUN;
              skip_d   = 1'b1;
              bp_hit_d = 1'b0;
            end
            OP_STEP: begin
              state_d  = ST_STEP;
              bp_hit_d = 1'b0;
            end
            OP_CPU_RST: enter_crst = 1'b1;
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALT;
      end
      ST_RUN: begin
        cpu_en = !bp_match;
        skip_d = 1'b0;
        // CPU_RST outranks a breakpoint hit; a breakpoint outranks HALT so bp_hit still records it
        if (accept && op == OP_CPU_RST) begin
          enter_crst = 1'b1;
        end else if (bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else if (accept && op == OP_HALT) begin
          state_d = ST_HALT;
        end
      end
      default: ;
    endcase

    if (accept) begin
      case (op)
        OP_SET_BP: begin
          bp_addr_d  = cmd_arg;
          bp_valid_d = 1'b1;
        end
        OP_CLR_BP:  bp_valid_d = 1'b0;
        OP_CLR_CNT: clr_cnt    = 1'b1;
        default: ;
      endcase
    end

    if (enter_crst) begin
      state_d   = ST_CRST;
      rst_cnt_d = RST_LOAD;
      bp_hit_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CRST;
      rst_cnt_q  <= RST_LOAD;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      bp_hit_q   <= 1'b0;
      skip_q     <= 1'b0;
      cpu_rst    <= 1'b1;
      halted     <= 1'b0;
      retired    <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      bp_hit_q   <= bp_hit_d;
      skip_q     <= skip_d;
      cpu_rst    <= (state_d == ST_CRST);
      halted     <= (state_d == ST_HALT);
      if (enter_crst || clr_cnt) retired <= '0;
      else if (cpu_en)           retired <= retired + CNT_W'(1);
    end
  end

  assign bp_hit = bp_hit_q;
  assign state  = state_q;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// Directed bench for sc_run_ctrl: reset release, step, breakpoints, halt, counter.
module tb_sc_run_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3,
                         SET_BP = 3'd4, CLR_BP = 3'd5, CPU_RST = 3'd6, CLR_CNT = 3'd7;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [31:0]   cmd_arg;
  logic [31:0]   pc;
  logic          cpu_en;
  logic          cpu_rst;
  logic          halted;
  logic          bp_hit;
  logic [1:0]    state;
  logic [CW-1:0] retired;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  sc_run_ctrl #(.CNT_W(CW), .RST_CYC(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .pc       (pc),
    .cpu_en   (cpu_en),
    .cpu_rst  (cpu_rst),
    .halted   (halted),
    .bp_hit   (bp_hit),
    .state    (state),
    .retired  (retired)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; idle(); cmd_arg = '0; pc = '0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_bp_hit", 32'(bp_hit), 0);
    chk("rst_retired", 32'(retired), 0);

    // release: cpu_rst for exactly two cycles
    reset = 1'b0; #1;
    chk("rel1_cpu_rst", 32'(cpu_rst), 1);
    chk("rel1_ready", 32'(cmd_ready), 0);
    tick();
    chk("rel2_cpu_rst", 32'(cpu_rst), 1);
    chk("rel2_ready", 32'(cmd_ready), 0);
    tick();
    chk("rel_cpu_rst_low", 32'(cpu_rst), 0);
    chk("rel_halted", 32'(halted), 1);
    chk("rel_cpu_en", 32'(cpu_en), 0);
    chk("rel_retired", 32'(retired), 0);
    chk("rel_state", 32'(state), 1);

    // single step
    pc = 32'h0; cmd(STEP, 0); #1;
    chk("step_ready_halt", 32'(cmd_ready), 1);
    chk("step_en_halt", 32'(cpu_en), 0);
    tick(); idle(); #1;
    chk("step_state", 32'(state), 3);
    chk("step_en", 32'(cpu_en), 1);
    chk("step_ready", 32'(cmd_ready), 0);
    tick(); pc = 32'h4; #1;
    chk("step_done_halted", 32'(halted), 1);
    chk("step_done_en", 32'(cpu_en), 0);
    chk("step_retired", 32'(retired), 1);

    // run to breakpoint at 0x10
    cmd(CLR_CNT, 0); tick();
    cmd(SET_BP, 32'h10); tick();
    pc = 32'h0; cmd(RUN, 0); #1;
    chk("clr_cnt_halt", 32'(retired), 0);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_run_en", 32'(cpu_en), 1);
      tick(); pc = pc + 32'h4;
    end
    #1;
    chk("bp_en_at_bp", 32'(cpu_en), 0);
    chk("bp_state_run", 32'(state), 2);
    tick(); #1;
    chk("bp_halted", 32'(halted), 1);
    chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_retired", 32'(retired), 4);

    // resume over breakpoint, then hit it again
    cmd(RUN, 0); #1;
    chk("res_ready", 32'(cmd_ready), 1);
    tick(); idle(); #1;
    chk("res_en_first", 32'(cpu_en), 1);
    chk("res_bp_hit_clr", 32'(bp_hit), 0);
    tick(); pc = 32'h14; #1;
    chk("res_en_14", 32'(cpu_en), 1);
    tick(); pc = 32'h10; #1;
    chk("res_en_back", 32'(cpu_en), 0);
    tick(); #1;
    chk("res_halted", 32'(halted), 1);
    chk("res_bp_hit", 32'(bp_hit), 1);
    chk("res_retired", 32'(retired), 6);

    // HALT command away from the breakpoint: current instruction still executes
    pc = 32'h20; cmd(RUN, 0); tick(); idle(); #1;
    chk("hcmd_en_20", 32'(cpu_en), 1);
    tick(); pc = 32'h24; cmd(HALT, 0); #1;
    chk("hcmd_en_24", 32'(cpu_en), 1);
    tick(); idle(); #1;
    chk("hcmd_halted", 32'(halted), 1);
    chk("hcmd_bp_hit", 32'(bp_hit), 0);
    chk("hcmd_retired", 32'(retired), 8);

    // HALT together with breakpoint match
    pc = 32'h10; cmd(RUN, 0); tick(); idle(); #1;
    chk("sim_en_skip", 32'(cpu_en), 1);
    tick(); cmd(HALT, 0); #1;
    chk("sim_en", 32'(cpu_en), 0);
    chk("sim_ready", 32'(cmd_ready), 1);
    tick(); idle(); #1;
    chk("sim_halted", 32'(halted), 1);
    chk("sim_bp_hit", 32'(bp_hit), 1);
    chk("sim_retired", 32'(retired), 9);

    // CPU_RST during RUN keeps the breakpoint
    pc = 32'h30; cmd(RUN, 0); tick(); cmd(CPU_RST, 0); #1;
    chk("crst_en_before", 32'(cpu_en), 1);
    tick(); idle(); #1;
    chk("crst_state", 32'(state), 0);
    chk("crst_cpu_rst1", 32'(cpu_rst), 1);
    chk("crst_retired", 32'(retired), 0);
    chk("crst_bp_hit", 32'(bp_hit), 0);
    chk("crst_ready", 32'(cmd_ready), 0);
    tick(); #1;
    chk("crst_cpu_rst2", 32'(cpu_rst), 1);
    tick(); #1;
    chk("crst_cpu_rst_low", 32'(cpu_rst), 0);
    chk("crst_halted", 32'(halted), 1);
    pc = 32'hC; cmd(RUN, 0); tick(); idle(); #1;
    chk("keep_en_c", 32'(cpu_en), 1);
    tick(); pc = 32'h10; #1;
    chk("keep_en_bp", 32'(cpu_en), 0);
    tick(); #1;
    chk("keep_bp_hit", 32'(bp_hit), 1);
    chk("keep_retired", 32'(retired), 1);

    // CLR_CNT in a cycle with cpu_en=1
    cmd(RUN, 0); tick(); cmd(CLR_CNT, 0); #1;
    chk("cc_en", 32'(cpu_en), 1);
    tick(); idle(); pc = 32'h14; #1;
    chk("cc_retired", 32'(retired), 0);
    cmd(HALT, 0); tick(); idle(); #1;
    chk("cc_retired_after", 32'(retired), 1);
    chk("cc_halted", 32'(halted), 1);

    // counter wrap at 2^CW
    cmd(CLR_CNT, 0); tick();
    for (int i = 0; i < 15; i++) begin
      cmd(STEP, 0); tick(); idle(); tick();
    end
    #1;
    chk("wrap_max", 32'(retired), 32'hF);
    cmd(STEP, 0); tick(); idle(); tick(); #1;
    chk("wrap_zero", 32'(retired), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
